fetch_instr: RTL and testbench

FETCH_INSTR -- requirements
Module: fetch_instr

---
 rtl/fetch_instr.sv | 77 +++++++
 tb/tb_fetch_instr.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fetch_instr.sv
// fetch_instr: single-outstanding instruction fetch unit holding one word for the decoder,
// with redirect handling and a sticky misaligned-target fault.
module fetch_instr #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        resetFetch,
  input  logic        enableFetch,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        inst_ack,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misaligned
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic        valid_q, valid_d, mis_q, mis_d, req_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    if (state_q != ERR) begin
      if (redirect) begin
        pc_d    = redirect_pc;
        inst_d  = NOP_INST;
        valid_d = 1'b0;
        mis_d   = redirect_pc[1:0] != 2'b00;
        state_d = mis_d ? ERR : (enableFetch ? REQ : IDLE);
      end else if (state_q == IDLE) begin
        state_d = enableFetch ? REQ : IDLE;
      end else if (state_q == REQ && mem_ready) begin
        inst_d  = mem_rdata;
        valid_d = 1'b1;
        state_d = HOLD;
      end else if (state_q == HOLD && inst_ack) begin
        pc_d    = pc_q + 32'd4;
        inst_d  = NOP_INST;
        valid_d = 1'b0;
        state_d = enableFetch ? REQ : IDLE;
      end
    end
  end
  // mem_req is registered from the next state so it changes only with the FSM
  always_ff @(posedge clock or posedge resetFetch) begin
    if (resetFetch) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      req_q   <= state_d == REQ;
    end
  end
  assign mem_req    = req_q;
  assign mem_addr   = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign misaligned = mis_q;
endmodule

// File: tb/tb_fetch_instr.sv
// tb_fetch_instr: randomized + directed bench; a transaction-level model predicts fetches,
// a scoreboard queue carries expected {pc,inst} pairs to an independent output monitor.
module tb_fetch_instr;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clock = 1'b0, resetFetch = 1'b1, enableFetch = 1'b0;
  logic        mem_req, mem_ready = 1'b0, inst_valid, inst_ack = 1'b0, redirect = 1'b0, misaligned;
  logic [31:0] mem_addr, mem_rdata = '0, inst, pc, redirect_pc = '0;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] sb_q[$];
  // transaction-level model: one fetch is either wanted, held, or blocked by a fault
  bit          m_want, m_have, m_err;
  logic [31:0] m_pc;

  fetch_instr dut (
    .clock(clock), .resetFetch(resetFetch), .enableFetch(enableFetch),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .inst(inst), .pc(pc), .inst_valid(inst_valid), .inst_ack(inst_ack),
    .redirect(redirect), .redirect_pc(redirect_pc), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_want = 0; m_have = 0; m_err = 0; m_pc = 32'h0;
    sb_q.delete();
  endtask

  task automatic check_outputs();
    chk("mem_req", {31'b0, mem_req}, {31'b0, m_want});
    chk("mem_addr", mem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_have});
    chk("misaligned", {31'b0, misaligned}, {31'b0, m_err});
  endtask

  task automatic cycle(input bit en, input bit rdy, input logic [31:0] rd, input bit ack,
                       input bit rdr, input logic [31:0] rpc);
    enableFetch = en; mem_ready = rdy; mem_rdata = rd; inst_ack = ack;
    redirect = rdr; redirect_pc = rpc;
    @(posedge clock);
    if (resetFetch) model_reset();
    else if (m_err) ;
    else if (rdr) begin
      m_pc = rpc; m_have = 0;
      m_err = rpc % 4 != 0;
      m_want = !m_err && en;
    end else if (m_have) begin
      if (ack) begin m_pc = m_pc + 4; m_have = 0; m_want = en; end
    end else if (m_want) begin
      if (rdy) begin sb_q.push_back({m_pc, rd}); m_have = 1; m_want = 0; end
    end else m_want = en;
    @(negedge clock);
    check_outputs();
  endtask

  task automatic do_reset();
    resetFetch = 1'b1;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    model_reset();
    cycle(1, 1, 32'hDEAD_BEEF, 1, 0, 0);
    resetFetch = 1'b0;
  endtask

  bit          prev_valid = 0;
  logic [31:0] cur_inst, cur_pc;
  always @(negedge clock) begin
    if (resetFetch) prev_valid = 0;
    else begin
      if (inst_valid && !prev_valid) begin
        if (sb_q.size() == 0) chk("unexpected_episode", inst, NOP);
        else begin
          {cur_pc, cur_inst} = sb_q.pop_front();
          chk("sb_inst", inst, cur_inst);
          chk("sb_pc", pc, cur_pc);
        end
      end else if (inst_valid) begin
        chk("hold_inst", inst, cur_inst);
        chk("hold_pc", pc, cur_pc);
      end else chk("nop_inst", inst, NOP);
      prev_valid = inst_valid;
    end
  end

  initial begin
    int err_cycles = 0;
    model_reset();
    @(negedge clock);
    do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h0050_0093, 0, 0, 0);
    repeat (5) cycle(1, $urandom_range(0, 1), $urandom, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    chk("addr_after_ack", mem_addr, 32'h4);
    cycle(1, 1, 32'h1234_5678, 0, 1, 32'h100);
    chk("redirect_addr", mem_addr, 32'h100);
    cycle(1, 1, 32'hAAAA_0001, 0, 1, 32'hFFFF_FFFC);
    cycle(1, 1, 32'hAAAA_0002, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    chk("wrap_addr", mem_addr, 32'h0);
    cycle(1, 0, 0, 0, 1, 32'h102);
    repeat (6) cycle(1, 1, $urandom, 1, 1, 32'h200);
    chk("err_sticky", {31'b0, misaligned}, 32'h1);
    do_reset();
    cycle(1, 0, 0, 0, 0, 0);
    do_reset();
    cycle(0, 1, 32'hBAD0_0000, 0, 0, 0);
    chk("late_ready_valid", {31'b0, inst_valid}, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = {$urandom_range(0, 255), 2'b00} << 2;
      if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, rpc);
      err_cycles = m_err ? err_cycles + 1 : 0;
      if (err_cycles > 8 || $urandom_range(0, 299) == 0) begin
        do_reset();
        err_cycles = 0;
      end
    end
    cycle(0, 0, 0, 0, 0, 0);
    chk("sb_drained", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
